stack_mem_controller: RTL and testbench
=======================================

Name: stack_mem_controller

Overview:
- Bus initiator that drives the processor's 16-bit data memory on its stack port and its random-read port.
- Accepts PUSH / POP / PEEK / LOAD requests from the accumulator datapath over a Req/Ack handshake.
- Owns the stack pointer and sequences writes and reads with the memory's timing:
  - write at the clock edge;
  - stack read data valid one cycle after the SP is sampled;
  - random read combinational while MemRead is high.
- Reports full/empty and stack errors.

Parameters:
- DATA_WIDTH, 16, width of data, address and SP.
- SP_INIT, 16'hFFFF, SP value when the stack is empty. The stack grows down and SP points at the next free slot.
- SP_LIMIT, 16'hFF00, lowest usable stack address. Capacity is SP_INIT-SP_LIMIT+1 entries.

Ports:
- CLK  in  1  clock
- RST_n  in  1  asynchronous active-low reset
- Req  in  1  request, sampled only in IDLE
- Op  in  2  operation: 00 PUSH, 01 POP, 10 LOAD, 11 PEEK
- Wr_Data  in  DATA_WIDTH  push data
- Addr  in  DATA_WIDTH  LOAD address
- Ack  out  1  one-cycle completion pulse
- Err  out  1  valid with Ack; overflow or underflow
- Busy  out  1  high in every state except IDLE
- Rd_Data  out  DATA_WIDTH  POP/PEEK/LOAD result, held until next successful read
- Empty  out  1  SP==SP_INIT
- Full  out  1  SP==SP_LIMIT-1
- Mem_Wr_Data  out  DATA_WIDTH  to memory Data
- Mem_Addr  out  DATA_WIDTH  to memory Addr
- Mem_SP  out  DATA_WIDTH  to memory SP
- Mem_Write  out  1  to memory Mem_Write
- MemRead  out  1  to memory MemRead
- Mem_Data  in  DATA_WIDTH  from memory Mem_Data
- SP_Data  in  DATA_WIDTH  from memory SP_Data

Behaviour:
- Reset (async, RST_n=0) forces the following immediately:
  - state IDLE;
  - SP=SP_INIT, Mem_SP=SP_INIT;
  - Mem_Addr=0, Mem_Wr_Data=0, Rd_Data=0;
  - Mem_Write=0, MemRead=0, Ack=0, Err=0, Busy=0.
- Reset mid-operation aborts the operation with no Ack. A PUSH in PUSH_WR is dropped because Mem_Write falls asynchronously before the edge.
- All outputs are registered. Empty and Full are decoded from the SP register.
- States: IDLE, PUSH_WR, RD_WAIT, RD_CAP, LOAD_RD, DONE.
- IDLE, on a clock edge with Req=1:
  - PUSH with Full=1, or POP/PEEK with Empty=1: go to DONE with Err=1. There is no memory access and SP and Rd_Data are unchanged. Ack comes 1 cycle after the accept edge.
  - PUSH: latch Mem_Wr_Data=Wr_Data and Mem_SP=SP, then go to PUSH_WR.
  - POP: SP<=SP+1, Mem_SP<=SP+1, then go to RD_WAIT.
  - PEEK: Mem_SP<=SP+1 with SP unchanged, then go to RD_WAIT.
  - LOAD: Mem_Addr<=Addr, then go to LOAD_RD.
- PUSH_WR: Mem_Write=1 for exactly this cycle. At the edge the memory writes ram[Mem_SP], SP<=SP-1, then go to DONE. Ack comes 2 cycles after accept.
- RD_WAIT: the memory registers Mem_SP at the edge, then go to RD_CAP.
- RD_CAP: Rd_Data<=SP_Data at the edge, then go to DONE. Ack comes 3 cycles after accept.
- LOAD_RD: MemRead=1 for exactly this cycle. Rd_Data<=Mem_Data at the edge, then go to DONE. Ack comes 2 cycles after accept.
- DONE: Ack=1 and Err is valid, then return to IDLE. Err clears when Ack clears.
  - A Req held high into IDLE is treated as a new request.
  - Back-to-back throughput is one operation per (latency+1) cycles.
- Mem_SP is held outside the active states, so the memory's SP_Data tracks ram[Mem_SP].
- SP arithmetic is modulo 2^DATA_WIDTH, but the full/empty checks prevent SP from leaving SP_LIMIT-1..SP_INIT.
- Op and Wr_Data/Addr are sampled only at the accept edge. Changes while Busy=1 are ignored.

Decomposition:
- Shared package: op encodings (OP_PUSH, OP_POP, OP_LOAD, OP_PEEK) and the state encoding constants, also used by the datapath decoder.
- Single module; no sub-module is warranted.

Test Plan:
- Reset, then PUSH 16'hA5A5: Mem_Write=1 for one cycle with Mem_SP=16'hFFFF. Ack 2 cycles after accept with Err=0, SP=16'hFFFE, Empty=0.
- PUSH 16'h1111 then 16'h2222, then POP twice: Rd_Data=16'h2222 then 16'h1111. Each Ack is 3 cycles after accept. Empty=1 at the end.
- PUSH 16'h00FF, PEEK twice: Rd_Data=16'h00FF both times and SP stays at 16'hFFFE.
- Preload memory[16'h0040]=16'hBEEF, LOAD Addr=16'h0040: MemRead=1 for one cycle. Ack 2 cycles after accept with Rd_Data=16'hBEEF. Mem_Write stays 0.
- With SP_INIT=16'h0003 and SP_LIMIT=16'h0000, do 4 pushes to reach Full=1:
  - a 5th PUSH gives Ack 1 cycle after accept with Err=1, no Mem_Write, SP=16'hFFFF (SP_LIMIT-1);
  - a POP on an empty stack likewise gives Err=1.
- Assert RST_n=0 during PUSH_WR: Mem_Write drops immediately, no Ack, SP=SP_INIT. The next PUSH after release completes normally.

Source files
------------

// File: rtl/stack_mem_controller_pkg.sv
// Shared encodings for the stack/memory controller. The accumulator datapath
// decoder also uses these.
package stack_mem_controller_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_LOAD = 2'b10,
    OP_PEEK = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PUSH_WR = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_CAP  = 3'd3,
    ST_LOAD_RD = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/stack_mem_controller.sv
// Stack-pointer owner and bus initiator for the 16-bit data memory: turns
// PUSH/POP/PEEK/LOAD requests into timed stack-port and random-read accesses.
module stack_mem_controller
  import stack_mem_controller_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] SP_INIT    = 16'hFFFF,
  parameter logic [DATA_WIDTH-1:0] SP_LIMIT   = 16'hFF00
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  Req,
  input  logic [1:0]            Op,
  input  logic [DATA_WIDTH-1:0] Wr_Data,
  input  logic [DATA_WIDTH-1:0] Addr,
  output logic                  Ack,
  output logic                  Err,
  output logic                  Busy,
  output logic [DATA_WIDTH-1:0] Rd_Data,
  output logic                  Empty,
  output logic                  Full,
  output logic [DATA_WIDTH-1:0] Mem_Wr_Data,
  output logic [DATA_WIDTH-1:0] Mem_Addr,
  output logic [DATA_WIDTH-1:0] Mem_SP,
  output logic                  Mem_Write,
  output logic                  MemRead,
  input  logic [DATA_WIDTH-1:0] Mem_Data,
  input  logic [DATA_WIDTH-1:0] SP_Data
);

  localparam logic [DATA_WIDTH-1:0] SP_FULL = SP_LIMIT - 1'b1;
  localparam logic [DATA_WIDTH-1:0] ONE     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   sp_q, sp_d;
  logic [DATA_WIDTH-1:0]   mem_sp_q, mem_sp_d;
  logic [DATA_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    mem_write_q, mem_write_d;
  logic                    mem_read_q, mem_read_d;
  logic                    empty, full;
  logic [DATA_WIDTH-1:0]   sp_inc;

  assign empty  = (sp_q == SP_INIT);
  assign full   = (sp_q == SP_FULL);
  assign sp_inc = sp_q + ONE;

  always_comb begin
    state_d       = state_q;
    sp_d          = sp_q;
    mem_sp_d      = mem_sp_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    rd_data_d     = rd_data_q;
    err_d         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Req) begin
          case (Op)
            OP_PUSH: begin
              if (full) begin
                state_d = ST_DONE;
                err_d   = 1'b1;
              end else begin
                mem_wr_data_d = Wr_Data;
                mem_sp_d      = sp_q;
                state_d       = ST_PUSH_WR;
              end
            end
            OP_POP: begin
              if (empty) begin
                state_d = ST_DONE;
                err_d   = 1'b1;
              end else begin
                sp_d     = sp_inc;
                mem_sp_d = sp_inc;
                state_d  = ST_RD_WAIT;
              end
            end
            OP_PEEK: begin
              if (empty) begin
                state_d = ST_DONE;
                err_d   = 1'b1;
              end else begin
                mem_sp_d = sp_inc;
                state_d  = ST_RD_WAIT;
              end
            end
            default: begin
              mem_addr_d = Addr;
              state_d    = ST_LOAD_RD;
            end
          endcase
        end
      end
      ST_PUSH_WR: begin
        sp_d    = sp_q - ONE;
        state_d = ST_DONE;
      end
      // Memory latches Mem_SP on this edge; SP_Data is valid in RD_CAP.
      ST_RD_WAIT: state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        rd_data_d = SP_Data;
        state_d   = ST_DONE;
      end
      ST_LOAD_RD: begin
        rd_data_d = Mem_Data;
        state_d   = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Strobes are registered copies of the next-state decode so that they
    // line up exactly with the state they belong to.
    ack_d       = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
    mem_write_d = (state_d == ST_PUSH_WR);
    mem_read_d  = (state_d == ST_LOAD_RD);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q       <= ST_IDLE;
      sp_q          <= SP_INIT;
      mem_sp_q      <= SP_INIT;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      rd_data_q     <= '0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sp_q          <= sp_d;
      mem_sp_q      <= mem_sp_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      rd_data_q     <= rd_data_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      mem_write_q   <= mem_write_d;
      mem_read_q    <= mem_read_d;
    end
  end

  assign Ack         = ack_q;
  assign Err         = err_q;
  assign Busy        = busy_q;
  assign Rd_Data     = rd_data_q;
  assign Empty       = empty;
  assign Full        = full;
  assign Mem_Wr_Data = mem_wr_data_q;
  assign Mem_Addr    = mem_addr_q;
  assign Mem_SP      = mem_sp_q;
  assign Mem_Write   = mem_write_q;
  assign MemRead     = mem_read_q;

endmodule

// File: tb/tb_stack_mem_controller.sv
// Bench for stack_mem_controller: a default-sized instance and a tiny 4-entry
// instance, each with its own behavioural data memory.
module tb_stack_mem_controller;
  import stack_mem_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] wr_data = '0, addr = '0;
  bit          sel = 1'b0;
  bit          preload = 1'b1;

  logic        ack_a, err_a, busy_a, empty_a, full_a, mw_a, mr_a;
  logic        ack_b, err_b, busy_b, empty_b, full_b, mw_b, mr_b;
  logic [15:0] rd_a, wd_a, maddr_a, msp_a, mdata_a, spdata_a;
  logic [15:0] rd_b, wd_b, maddr_b, msp_b, mdata_b, spdata_b;

  always #5 clk = ~clk;

  stack_mem_controller dut_a (
    .CLK(clk), .RST_n(rst_n), .Req(req_a), .Op(op), .Wr_Data(wr_data), .Addr(addr),
    .Ack(ack_a), .Err(err_a), .Busy(busy_a), .Rd_Data(rd_a), .Empty(empty_a), .Full(full_a),
    .Mem_Wr_Data(wd_a), .Mem_Addr(maddr_a), .Mem_SP(msp_a), .Mem_Write(mw_a),
    .MemRead(mr_a), .Mem_Data(mdata_a), .SP_Data(spdata_a));

  stack_mem_controller #(.DATA_WIDTH(16), .SP_INIT(16'h0003), .SP_LIMIT(16'h0000)) dut_b (
    .CLK(clk), .RST_n(rst_n), .Req(req_b), .Op(op), .Wr_Data(wr_data), .Addr(addr),
    .Ack(ack_b), .Err(err_b), .Busy(busy_b), .Rd_Data(rd_b), .Empty(empty_b), .Full(full_b),
    .Mem_Wr_Data(wd_b), .Mem_Addr(maddr_b), .Mem_SP(msp_b), .Mem_Write(mw_b),
    .MemRead(mr_b), .Mem_Data(mdata_b), .SP_Data(spdata_b));

  // Behavioural memories: write at the edge, registered SP port, combinational random read.
  bit   [15:0] ram_a [0:65535];
  bit   [15:0] ram_b [0:65535];
  logic [15:0] spreg_a = '0, spreg_b = '0, last_wr_a = '0;
  int          wcnt_a = 0, wcnt_b = 0, rcnt_a = 0, rcnt_b = 0;

  always @(posedge clk) begin
    if (preload) ram_a[16'h0040] <= 16'hBEEF;
    else if (mw_a) begin
      ram_a[msp_a] <= wd_a;
      last_wr_a    <= msp_a;
    end
    if (mw_b) ram_b[msp_b] <= wd_b;
    spreg_a <= msp_a;
    spreg_b <= msp_b;
    if (mw_a) wcnt_a <= wcnt_a + 1;
    if (mw_b) wcnt_b <= wcnt_b + 1;
    if (mr_a) rcnt_a <= rcnt_a + 1;
    if (mr_b) rcnt_b <= rcnt_b + 1;
  end

  assign spdata_a = ram_a[spreg_a];
  assign spdata_b = ram_b[spreg_b];
  assign mdata_a  = mr_a ? ram_a[maddr_a] : 16'h0000;
  assign mdata_b  = mr_b ? ram_b[maddr_b] : 16'h0000;

  // Views of whichever instance is under test.
  logic        ack, err, busy, empty, full;
  logic [15:0] rd, sp;
  assign ack   = sel ? ack_b   : ack_a;
  assign err   = sel ? err_b   : err_a;
  assign busy  = sel ? busy_b  : busy_a;
  assign empty = sel ? empty_b : empty_a;
  assign full  = sel ? full_b  : full_a;
  assign rd    = sel ? rd_b    : rd_a;
  assign sp    = sel ? dut_b.sp_q : dut_a.sp_q;

  typedef struct {
    bit          sel;
    logic [1:0]  op;
    logic [15:0] data;
    logic [15:0] addr;
    bit          err;
    logic [15:0] rd;
    int          lat;
    logic [15:0] sp;
    bit          empty;
    bit          full;
  } vec_t;

  typedef struct {
    bit          err;
    logic [15:0] rd;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   wc0, rc0, lat;
    bit   got;
    exp_t e;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    sel = v.sel; op = v.op; wr_data = v.data; addr = v.addr;
    if (v.sel) req_b = 1'b1; else req_a = 1'b1;
    exp_q.push_back('{v.err, v.rd});
    wc0 = v.sel ? wcnt_b : wcnt_a;
    rc0 = v.sel ? rcnt_b : rcnt_a;
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    lat = 1;
    got = 1'b0;
    while (!got && lat <= 12) begin
      if (ack) got = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s_ack_timeout: no Ack within 12 cycles", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_lat"}, lat, v.lat);
    chk({tag, "_err"}, err, e.err);
    chk({tag, "_rd"}, rd, e.rd);
    chk({tag, "_sp"}, sp, v.sp);
    chk({tag, "_empty"}, empty, v.empty);
    chk({tag, "_full"}, full, v.full);
    chk({tag, "_writes"}, (v.sel ? wcnt_b : wcnt_a) - wc0,
        (v.op == OP_PUSH && !v.err) ? 1 : 0);
    chk({tag, "_reads"}, (v.sel ? rcnt_b : rcnt_a) - rc0,
        (v.op == OP_LOAD) ? 1 : 0);
    @(posedge clk); #1;
    chk({tag, "_ack_pulse"}, ack, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    // sel op data addr err rd lat sp empty full
    vecs.push_back('{0, OP_PUSH, 16'hA5A5, 16'h0, 0, 16'h0000, 2, 16'hFFFE, 0, 0});
    vecs.push_back('{0, OP_POP,  16'h0,    16'h0, 0, 16'hA5A5, 3, 16'hFFFF, 1, 0});
    vecs.push_back('{0, OP_PUSH, 16'h1111, 16'h0, 0, 16'hA5A5, 2, 16'hFFFE, 0, 0});
    vecs.push_back('{0, OP_PUSH, 16'h2222, 16'h0, 0, 16'hA5A5, 2, 16'hFFFD, 0, 0});
    vecs.push_back('{0, OP_POP,  16'h0,    16'h0, 0, 16'h2222, 3, 16'hFFFE, 0, 0});
    vecs.push_back('{0, OP_POP,  16'h0,    16'h0, 0, 16'h1111, 3, 16'hFFFF, 1, 0});
    vecs.push_back('{0, OP_POP,  16'h0,    16'h0, 1, 16'h1111, 1, 16'hFFFF, 1, 0});
    vecs.push_back('{0, OP_PEEK, 16'h0,    16'h0, 1, 16'h1111, 1, 16'hFFFF, 1, 0});
    vecs.push_back('{0, OP_PUSH, 16'h00FF, 16'h0, 0, 16'h1111, 2, 16'hFFFE, 0, 0});
    vecs.push_back('{0, OP_PEEK, 16'h0,    16'h0, 0, 16'h00FF, 3, 16'hFFFE, 0, 0});
    vecs.push_back('{0, OP_PEEK, 16'h0,    16'h0, 0, 16'h00FF, 3, 16'hFFFE, 0, 0});
    vecs.push_back('{0, OP_LOAD, 16'h0, 16'h0040, 0, 16'hBEEF, 2, 16'hFFFE, 0, 0});
    vecs.push_back('{0, OP_POP,  16'h0,    16'h0, 0, 16'h00FF, 3, 16'hFFFF, 1, 0});
    vecs.push_back('{1, OP_PUSH, 16'h0001, 16'h0, 0, 16'h0000, 2, 16'h0002, 0, 0});
    vecs.push_back('{1, OP_PUSH, 16'h0002, 16'h0, 0, 16'h0000, 2, 16'h0001, 0, 0});
    vecs.push_back('{1, OP_PUSH, 16'h0003, 16'h0, 0, 16'h0000, 2, 16'h0000, 0, 0});
    vecs.push_back('{1, OP_PUSH, 16'h0004, 16'h0, 0, 16'h0000, 2, 16'hFFFF, 0, 1});
    vecs.push_back('{1, OP_PUSH, 16'h0005, 16'h0, 1, 16'h0000, 1, 16'hFFFF, 0, 1});
    vecs.push_back('{1, OP_POP,  16'h0,    16'h0, 0, 16'h0004, 3, 16'h0000, 0, 0});
    vecs.push_back('{1, OP_POP,  16'h0,    16'h0, 0, 16'h0003, 3, 16'h0001, 0, 0});
    vecs.push_back('{1, OP_POP,  16'h0,    16'h0, 0, 16'h0002, 3, 16'h0002, 0, 0});
    vecs.push_back('{1, OP_POP,  16'h0,    16'h0, 0, 16'h0001, 3, 16'h0003, 1, 0});
    vecs.push_back('{1, OP_POP,  16'h0,    16'h0, 1, 16'h0001, 1, 16'h0003, 1, 0});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_mw", mw_a, 0);
    chk("rst_mr", mr_a, 0);
    chk("rst_rd", rd_a, 16'h0000);
    chk("rst_maddr", maddr_a, 16'h0000);
    chk("rst_wd", wd_a, 16'h0000);
    chk("rst_msp_a", msp_a, 16'hFFFF);
    chk("rst_msp_b", msp_b, 16'h0003);
    chk("rst_empty", empty_a, 1);
    chk("rst_full", full_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    preload = 1'b0;

    // First push: check the write address the memory actually saw
    run_vec(0, vecs[0]);
    chk("push0_addr", last_wr_a, 16'hFFFF);
    chk("push0_data", ram_a[16'hFFFF], 16'hA5A5);
    for (int i = 1; i < vecs.size(); i++) run_vec(i, vecs[i]);
    chk("sb_drained", exp_q.size(), 0);

    // Reset in the middle of PUSH_WR: the write must not land
    @(negedge clk);
    sel = 1'b0; op = OP_PUSH; wr_data = 16'hDEAD; req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0;
    chk("abort_mw_hi", mw_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_mw_drop", mw_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_msp", msp_a, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_ack", ack_a, 0);
    end
    chk("abort_no_write", ram_a[16'hFFFF], 16'h00FF);
    chk("abort_sp", dut_a.sp_q, 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(100, '{0, OP_PUSH, 16'h7777, 16'h0, 0, 16'h0000, 2, 16'hFFFE, 0, 0});
    chk("post_rst_data", ram_a[16'hFFFF], 16'h7777);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
